split_router: RTL and testbench

- Counterpart of the merge router: takes flits from one selected input direction and multicasts each flit unchanged to every direction in a static output mask.
- Port order is [0]-local [1]-west [2]-east [3]-north [4]-south.
- The block contains one input FIFO and per-output delivery tracking, so each flit reaches each destination exactly once, even when the output ready signals arrive on different cycles.

---
 rtl/split_router.sv | 172 +++++++++++++++++
 tb/tb_split_router.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/split_router.sv
// -----------------------------------------------------------------------------
// split_router
//
// Multicast splitter: flits arriving on one statically selected input
// direction are buffered in a small first-word-fall-through FIFO and each
// flit is delivered, unmodified, exactly once to every direction in a static
// output mask. Every destination has its own "served" bit. This lets slow
// outputs accept the head flit on later cycles than fast ones without the
// fast ones seeing a duplicate. The head pops on the edge where the last
// outstanding destination accepts it.
//
// Direction index: [0] local, [1] west, [2] east, [3] north, [4] south.
//
// Ports:
//   clk      - clock
//   rst      - asynchronous, active-high reset
//   data_i   - input flit per direction (only input_sel is used)
//   valid_i  - input valid per direction (only input_sel is used)
//   ready_o  - input ready per direction (0 for non-selected inputs)
//   data_o   - output flit per direction (0 for unmasked outputs)
//   valid_o  - output valid per direction (0 for unmasked outputs)
//   ready_i  - downstream ready per direction (ignored for unmasked outputs)
// -----------------------------------------------------------------------------
module split_router #(
   parameter int         DATA_W      = 8,
   parameter logic [0:4] input_sel   = 5'b00000,
   parameter logic [0:4] output_mask = 5'b00000,
   parameter int         DEPTH       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_i  [5],
   input  logic [0:4]        valid_i,
   output logic [0:4]        ready_o,
   output logic [DATA_W-1:0] data_o  [5],
   output logic [0:4]        valid_o,
   input  logic [0:4]        ready_i
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   function automatic int ones5(input logic [0:4] v);
      int n;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   function automatic int sel_index(input logic [0:4] v);
      int idx;
      idx = 0;
      for (int i = 0; i < 5; i++) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

   localparam int SEL = sel_index(input_sel);

   // Elaboration-time parameter sanity checks.
   generate
      if (ones5(input_sel) != 1) begin : g_bad_input_sel
         $error("split_router: input_sel must have exactly one bit set");
      end
      if (output_mask == 5'b00000) begin : g_zero_mask
         $error("split_router: output_mask must not be zero");
      end
      if ((input_sel & output_mask) != 5'b00000) begin : g_loop_mask
         $error("split_router: output_mask must not include the input direction");
      end
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("split_router: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q,  count_d;
   logic [0:4]        served_q, served_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              done;
   logic [0:4]        acc;
   logic [DATA_W-1:0] head;

   // ---------------------------------------------------------------------
   // FIFO status and input handshake
   // ---------------------------------------------------------------------
   always_comb begin
      full  = (count_q == CW'(DEPTH));
      empty = (count_q == '0);
      head  = mem_q[rd_ptr_q];

      // Ready depends only on the registered count, so a full FIFO stays
      // closed even on a cycle where the head is being popped.
      ready_o      = '0;
      ready_o[SEL] = ~full;
      push         = valid_i[SEL] & ~full;
   end

   // ---------------------------------------------------------------------
   // Output drive and per-destination delivery tracking
   // ---------------------------------------------------------------------
   always_comb begin
      for (int d = 0; d < 5; d++) begin
         // A served destination stays quiet until the head pops, which is
         // what prevents duplicates while other outputs are still pending.
         valid_o[d] = output_mask[d] & ~empty & ~served_q[d];
         data_o[d]  = (output_mask[d] & ~empty) ? head : '0;
      end

      acc  = valid_o & ready_i;

      // The head is complete once every masked destination has either been
      // served earlier or accepts it now.
      done = ~empty & (((served_q | acc) & output_mask) == output_mask);
      pop  = done;

      served_d = done ? 5'b00000 : (served_q | acc);
   end

   // ---------------------------------------------------------------------
   // Pointer and occupancy update
   // ---------------------------------------------------------------------
   always_comb begin
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         served_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         served_q <= served_d;
      end
   end

   // Storage is not reset: every read is qualified by the reset count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i[SEL];
      end
   end

   // Inputs of non-selected directions are intentionally ignored.
   logic unused_inputs;
   always_comb begin
      unused_inputs = ^valid_i;
      for (int i = 0; i < 5; i++) begin
         unused_inputs = unused_inputs ^ (^data_i[i]);
      end
   end

endmodule

// File: tb/tb_split_router.sv
module tb_split_router;

   localparam int         DW    = 8;
   localparam int         DEPTH = 8;
   localparam logic [0:4] SEL   = 5'b10000;   // local
   localparam logic [0:4] MASK  = 5'b01100;   // west | east
   localparam int         S     = 0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_i [5] = '{default: '0};
   logic [0:4]    valid_i = '0;
   logic [0:4]    ready_o;
   logic [DW-1:0] data_o [5];
   logic [0:4]    valid_o;
   logic [0:4]    ready_i = '0;

   split_router #(
      .DATA_W(DW), .input_sel(SEL), .output_mask(MASK), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
   );

   always #5 clk = ~clk;

   // Stimulus controls (written by the main sequence, applied by the driver).
   logic          src_valid = 1'b0;
   logic [DW-1:0] src_data  = '0;
   int            rdy_mode  = 0;     // 0 all ready, 1 random, 2 none, 3 manual
   logic [0:4]    rdy_man   = '0;
   bit            noise     = 1'b0;

   // Scoreboard: per masked output, the flits it still has to receive.
   logic [DW-1:0] exp_q [5][$];
   bit            in_acc = 1'b0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Driver: applies controls shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      valid_i[S] = src_valid;
      data_i[S]  = src_data;
      for (int i = 1; i < 5; i++) begin
         valid_i[i] = noise ? 1'($urandom) : 1'b0;
         data_i[i]  = noise ? DW'($urandom) : '0;
      end
      for (int i = 0; i < 5; i++) begin
         case (rdy_mode)
            0:       ready_i[i] = 1'b1;
            1:       ready_i[i] = 1'($urandom);
            2:       ready_i[i] = 1'b0;
            default: ready_i[i] = rdy_man[i];
         endcase
      end
   end

   // Monitor and reference model, evaluated on the falling edge.
   // Occupancy equals the backlog of the slowest masked output; an output is
   // offered a flit only while it is not ahead of the slowest one.
   always @(negedge clk) begin
      int occ;
      bit ev [5];
      in_acc = 1'b0;
      if (rst) begin
         for (int d = 0; d < 5; d++) begin
            exp_q[d].delete();
            chk($sformatf("rst_valid_o[%0d]", d), 32'(valid_o[d]), 32'd0);
            chk($sformatf("rst_data_o[%0d]", d), 32'(data_o[d]), 32'd0);
            chk($sformatf("rst_ready_o[%0d]", d), 32'(ready_o[d]), 32'(d == S));
         end
      end else begin
         occ = 0;
         for (int d = 0; d < 5; d++)
            if (MASK[d] && exp_q[d].size() > occ) occ = exp_q[d].size();
         for (int d = 0; d < 5; d++) begin
            ev[d] = MASK[d] && (exp_q[d].size() > 0) && (exp_q[d].size() == occ);
            chk($sformatf("valid_o[%0d]", d), 32'(valid_o[d]), 32'(ev[d]));
            if (ev[d])
               chk($sformatf("data_o[%0d]", d), 32'(data_o[d]), 32'(exp_q[d][0]));
            else if (!MASK[d] || occ == 0)
               chk($sformatf("idle_data_o[%0d]", d), 32'(data_o[d]), 32'd0);
            chk($sformatf("ready_o[%0d]", d), 32'(ready_o[d]),
                32'((d == S) ? (occ < DEPTH) : 0));
         end
         for (int d = 0; d < 5; d++)
            if (ev[d] && ready_i[d]) void'(exp_q[d].pop_front());
         if (valid_i[S] && occ < DEPTH) begin
            in_acc = 1'b1;
            for (int d = 0; d < 5; d++)
               if (MASK[d]) exp_q[d].push_back(data_i[S]);
         end
      end
   end

   task automatic send(input logic [DW-1:0] v);
      int t;
      t = 0;
      src_valid = 1'b1;
      src_data  = v;
      do begin
         @(posedge clk); #1;
         t++;
      end while (!in_acc && t < 300);
      if (!in_acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", v);
      end
      src_valid = 1'b0;
   endtask

   function automatic int backlog();
      int n;
      n = 0;
      for (int d = 0; d < 5; d++)
         if (MASK[d]) n += exp_q[d].size();
      return n;
   endfunction

   task automatic drain();
      int t;
      t = 0;
      while (backlog() != 0 && t < 600) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_backlog", 32'(backlog()), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Back-to-back multicast with all outputs ready.
      rdy_mode = 0;
      send(8'h11); send(8'h22); send(8'h33);
      drain();

      // East stalls while west proceeds.
      rdy_man = '0;
      rdy_man[1] = 1'b1;
      rdy_mode = 3;
      send(8'h11); send(8'h22);
      repeat (3) @(posedge clk);
      #1 rdy_man[2] = 1'b1;
      drain();

      // Fill to full with no readers, ninth flit held until drain starts.
      rdy_mode = 2;
      for (int i = 0; i < 8; i++) send(DW'(8'h50 + i));
      fork
         send(8'h58);
         begin
            repeat (4) @(posedge clk);
            #1 rdy_mode = 0;
         end
      join
      drain();

      // Randomized per-output readiness, wraps the pointers several times.
      rdy_mode = 1;
      for (int i = 1; i <= 20; i++) send(DW'(i));
      drain();

      // Reset while the head is partly delivered (west done, east pending).
      rdy_man = '0;
      rdy_man[1] = 1'b1;
      rdy_mode = 3;
      send(8'h11);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      send(8'h44);
      drain();

      // Noise on non-selected inputs and unmasked ready lines.
      noise = 1'b1;
      rdy_mode = 1;
      for (int i = 0; i < 10; i++) send(DW'($urandom));
      drain();
      noise = 1'b0;

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
